// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults and read-FSM state type for the flatten buffer
package cnn_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int N_DEF = 8;
  typedef enum logic [1:0] {IDLE, BURST, GAPW} rd_state_t;
endpackage

// File: rtl/fc_flat_bank.sv
// fc_flat_bank: N x DATA_W register bank with write port, tail zero-fill and combinational read
// ports: clk; we/waddr/wdata write one entry; zero_en clears every entry at or above zfrom
// (a write to the same entry wins); raddr/rdata asynchronous read
module fc_flat_bank import cnn_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N = N_DEF,
  localparam int AW = N > 1 ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              zero_en,
  input  logic [CW-1:0]     zfrom,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [N];
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      if (we && waddr == AW'(i)) mem[i] <= wdata;
      else if (zero_en && CW'(i) >= zfrom) mem[i] <= '0;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fc_flatten_buf.sv
// fc_flatten_buf: ping-pong frame buffer turning a pooled sample stream into gapped N-sample bursts
// ports: clk, rst (sync, active-high); in_valid/in_ready/in_data upstream handshake;
// flush closes a partial frame (zero padded); out_valid/out_data/out_last registered burst output
// build option: FLAT_RELU_EN stores negative samples as 0
module fc_flatten_buf import cnn_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N = N_DEF,
  parameter int GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  localparam int AW = N > 1 ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  localparam int GW = 4;
  logic [CW-1:0] wr_idx, k_eff, rd_idx, nxt_idx;
  logic [GW-1:0] gap_cnt, nxt_gap;
  logic [1:0] full, full_nxt;
  logic [DATA_W-1:0] wdata, rdata0, rdata1, rdata, od;
  logic wr_bank, rd_bank, acc, fill, do_flush, close, free, emit, ov, ol;
  rd_state_t state, nxt;
  assign acc = in_valid & in_ready;
  assign fill = acc && wr_idx == CW'(N - 1);
  // fill level after this cycle's sample; a flush that coincides with the
  // frame-completing sample sees an empty frame and does nothing
  assign k_eff = wr_idx + CW'(acc);
  assign do_flush = flush && !fill && k_eff != '0;
  assign close = fill | do_flush;
`ifdef FLAT_RELU_EN
  assign wdata = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign wdata = in_data;
`endif
  fc_flat_bank #(.DATA_W(DATA_W), .N(N)) u_bank0 (
    .clk(clk), .we(acc && !wr_bank), .waddr(wr_idx[AW-1:0]), .wdata(wdata),
    .zero_en(do_flush && !wr_bank), .zfrom(k_eff), .raddr(rd_idx[AW-1:0]), .rdata(rdata0)
  );
  fc_flat_bank #(.DATA_W(DATA_W), .N(N)) u_bank1 (
    .clk(clk), .we(acc && wr_bank), .waddr(wr_idx[AW-1:0]), .wdata(wdata),
    .zero_en(do_flush && wr_bank), .zfrom(k_eff), .raddr(rd_idx[AW-1:0]), .rdata(rdata1)
  );
  assign rdata = rd_bank ? rdata1 : rdata0;
  always_comb begin
    full_nxt = full;
    if (free) full_nxt[rd_bank] = 1'b0;
    if (close) full_nxt[wr_bank] = 1'b1;
  end
  // the bank is released as its last entry is registered, so the writer can
  // reuse it while that entry is still on out_data; the final gap cycle
  // checks for a waiting frame itself so the gap is exactly GAP cycles
  always_comb begin
    emit = (state == IDLE || (state == GAPW && gap_cnt == GW'(GAP - 1))) ? full[rd_bank]
         : (state == BURST && rd_idx != CW'(N));
    nxt = state;
    nxt_idx = rd_idx;
    nxt_gap = gap_cnt;
    free = 1'b0;
    ov = 1'b0;
    od = '0;
    ol = 1'b0;
    if (emit) begin
      nxt = BURST;
      nxt_idx = rd_idx + 1'b1;
      ov = 1'b1;
      od = rdata;
      ol = rd_idx == CW'(N - 1);
      free = ol;
    end else if (state == BURST) begin
      nxt = GAPW;
      nxt_idx = '0;
      nxt_gap = '0;
    end else if (state == GAPW) begin
      nxt = gap_cnt == GW'(GAP - 1) ? IDLE : GAPW;
      nxt_gap = gap_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      full <= '0;
      wr_idx <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_idx <= '0;
      gap_cnt <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      state <= nxt;
      full <= full_nxt;
      wr_idx <= close ? '0 : k_eff;
      wr_bank <= wr_bank ^ close;
      rd_bank <= rd_bank ^ free;
      rd_idx <= nxt_idx;
      gap_cnt <= nxt_gap;
      in_ready <= !full_nxt[wr_bank ^ close];
      out_valid <= ov;
      out_data <= od;
      out_last <= ol;
    end
endmodule
